// File: rtl/wb_pkg.sv
// Shared types and default widths for the register-file write-back queue.
package wb_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int DEPTH    = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} wb_state_t;
endpackage

// File: rtl/wb_decoder_onehot.sv
// Binary register address to one-hot register select; all zeros when disabled.
module wb_decoder_onehot #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot
);
  // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end
endmodule

// File: rtl/wb_write_queue.sv
// Write-back queue feeding the register file write port; optional pending-write
// bypass lookup is compiled in with `define WB_BYPASS_EN.
module wb_write_queue
  import wb_pkg::*;
#(
  parameter int DATA_W   = wb_pkg::DATA_W,
  parameter int ADDR_W   = wb_pkg::ADDR_W,
  parameter int NUM_REGS = wb_pkg::NUM_REGS,
  parameter int DEPTH    = wb_pkg::DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       flush,
  input  logic                       wr_stall,
  output logic                       regWrite,
  output logic [NUM_REGS-1:0]        decOut,
  output logic [DATA_W-1:0]          writeData,
  input  logic [ADDR_W-1:0]          q_addr,
  output logic                       q_hit,
  output logic [DATA_W-1:0]          q_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Entry layout follows the wb_pkg widths.
  wb_entry_t       mem [DEPTH];
  wb_entry_t       head;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  wb_state_t       state, state_next;
  logic            pending, push, enq, pop;

  assign pending   = (count != '0);
  assign in_ready  = reset & ~flush & (state != FULL);
  assign push      = in_valid & in_ready;
  assign enq       = push & (in_addr != '0);  // r0 writes are accepted but dropped
  assign regWrite  = pending & ~wr_stall & ~flush;
  assign pop       = regWrite;
  assign head      = mem[rd_ptr];
  assign writeData = pending ? head.data : '0;

  wb_decoder_onehot #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_dec (
    .en    (regWrite),
    .addr  (head.addr),
    .onehot(decOut)
  );

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (enq) state_next = PARTIAL;
      PARTIAL: begin
        if (enq && !pop && count == FULL_CNT - CW'(1)) state_next = FULL;
        else if (pop && !enq && count == CW'(1))       state_next = EMPTY;
      end
      FULL:    if (pop) state_next = PARTIAL;
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_next;
      count <= count + CW'(enq) - CW'(pop);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (enq) wr_ptr <= wr_ptr + PW'(1);
    end
  end

  // NOTE: storage is not reset; an entry is only ever read while count marks it valid.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{addr: in_addr, data: in_data};
  end

`ifdef WB_BYPASS_EN
  logic [PW-1:0] idx;

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    idx    = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count && mem[idx].addr == q_addr && q_addr != '0) begin
        q_hit  = 1'b1;
        q_data = mem[idx].data;
      end
    end
  end
`else
  logic unused_q_addr;

  assign unused_q_addr = ^q_addr;
  assign q_hit         = 1'b0;
  assign q_data        = '0;
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_wb_write_queue;
  import wb_pkg::*;

  localparam int D  = 2;
  localparam int CW = $clog2(D) + 1;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, flush, wr_stall, regWrite, q_hit;
  logic [4:0]    in_addr, q_addr;
  logic [31:0]   in_data, decOut, writeData, q_data;
  logic [CW-1:0] count;

  wb_write_queue #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .flush    (flush),
    .wr_stall (wr_stall),
    .regWrite (regWrite),
    .decOut   (decOut),
    .writeData(writeData),
    .q_addr   (q_addr),
    .q_hit    (q_hit),
    .q_data   (q_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } req_t;

  req_t model_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input int a, input logic [31:0] d,
                       input bit fl, input bit st, input int qa);
    in_valid = v;
    in_addr  = 5'(a);
    in_data  = d;
    flush    = fl;
    wr_stall = st;
    q_addr   = 5'(qa);
  endtask

  // Expected outputs follow directly from the pending list and the current inputs.
  task automatic check_outputs();
    bit          exp_ready, exp_wr, exp_hit;
    logic [63:0] exp_dec;
    logic [31:0] exp_wd, exp_qd;
    exp_ready = (model_q.size() < D) && !flush;
    exp_wr    = (model_q.size() != 0) && !wr_stall && !flush;
    exp_dec   = exp_wr ? (64'd1 << model_q[0].addr) : 64'd0;
    exp_wd    = (model_q.size() != 0) ? model_q[0].data : 32'd0;
    exp_hit   = 1'b0;
    exp_qd    = 32'd0;
    if (BYP && q_addr != 0)
      foreach (model_q[i])
        if (model_q[i].addr == int'(q_addr)) begin
          exp_hit = 1'b1;
          exp_qd  = model_q[i].data;
        end
    check("count",     64'(count),     64'(model_q.size()));
    check("in_ready",  64'(in_ready),  64'(exp_ready));
    check("regWrite",  64'(regWrite),  64'(exp_wr));
    check("decOut",    64'(decOut),    exp_dec);
    check("writeData", 64'(writeData), 64'(exp_wd));
    check("q_hit",     64'(q_hit),     64'(exp_hit));
    check("q_data",    64'(q_data),    64'(exp_qd));
  endtask

  task automatic apply(input bit v, input int a, input logic [31:0] d,
                       input bit fl, input bit st, input int qa);
    @(negedge clk);
    drive(v, a, d, fl, st, qa);
    #1;
    check_outputs();
  endtask

  task automatic clock();
    bit ready, wr;
    @(posedge clk);
    ready = (model_q.size() < D) && !flush;
    wr    = (model_q.size() != 0) && !wr_stall && !flush;
    if (flush) model_q.delete();
    else begin
      if (wr) void'(model_q.pop_front());
      if (in_valid && ready && in_addr != 0) model_q.push_back('{int'(in_addr), in_data});
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    check("rst_regWrite", 64'(regWrite), 64'd0);
    check("rst_decOut",   64'(decOut),   64'd0);
    check("rst_count",    64'(count),    64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_q_hit",    64'(q_hit),    64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single write: presented the cycle after acceptance, drained on the next edge.
    apply(1, 5, 32'hDEADBEEF, 0, 0, 0); clock();
    apply(0, 0, 0, 0, 0, 0);
    check("single_regWrite", 64'(regWrite),  64'd1);
    check("single_decOut",   64'(decOut),    64'h0000_0020);
    check("single_data",     64'(writeData), 64'hDEADBEEF);
    clock();
    apply(0, 0, 0, 0, 0, 0);
    check("single_drained", 64'(count), 64'd0);
    clock();

    // r0 discard.
    apply(1, 0, 32'h1234, 0, 0, 0);
    check("r0_ready", 64'(in_ready), 64'd1);
    clock();
    apply(0, 0, 0, 0, 0, 0);
    check("r0_count", 64'(count),    64'd0);
    check("r0_wr",    64'(regWrite), 64'd0);
    clock();

    // Stall until full, then drain in order.
    apply(1, 3, 32'hA, 0, 1, 0); clock();
    apply(1, 7, 32'hB, 0, 1, 0); clock();
    apply(1, 9, 32'hF, 0, 1, 0);
    check("full_count", 64'(count),    64'd2);
    check("full_ready", 64'(in_ready), 64'd0);
    check("full_wr",    64'(regWrite), 64'd0);
    clock();
    apply(0, 0, 0, 0, 0, 0);
    check("drain0_dec", 64'(decOut), 64'h8);
    clock();
    apply(0, 0, 0, 0, 0, 0);
    check("drain1_dec", 64'(decOut), 64'h80);
    clock();

    // Simultaneous push/pop, then flush.
    apply(1, 1, 32'h1, 0, 0, 0); clock();
    apply(1, 9, 32'hC, 0, 0, 0); clock();
    apply(0, 0, 0, 0, 1, 0);
    check("pushpop_count", 64'(count), 64'd1);
    clock();
    apply(1, 2, 32'h2, 1, 0, 0);
    check("flush_wr",    64'(regWrite), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd0);
    clock();
    apply(0, 0, 0, 0, 0, 0);
    check("flush_count", 64'(count), 64'd0);
    clock();

    // Bypass lookup picks the youngest pending write.
    apply(1, 4, 32'h11, 0, 1, 4); clock();
    apply(1, 4, 32'h22, 0, 1, 4); clock();
    apply(0, 0, 0, 0, 1, 4);
    check("byp_hit",  64'(q_hit),  64'(BYP));
    check("byp_data", 64'(q_data), BYP ? 64'h22 : 64'h0);
    clock();
    apply(0, 0, 0, 0, 1, 0);
    check("byp_r0_hit", 64'(q_hit), 64'd0);
    clock();

    // Reset mid-traffic with two pending writes.
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("midrst_wr",    64'(regWrite),  64'd0);
    check("midrst_dec",   64'(decOut),    64'd0);
    check("midrst_count", 64'(count),     64'd0);
    check("midrst_wd",    64'(writeData), 64'd0);
    model_q.delete();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_ready", 64'(in_ready), 64'd1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      apply($urandom_range(0, 9) < 7,
            (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7))),
            $urandom,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 7));
      clock();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Write-back stage directly upstream of the register file's 32-bit registers.
- Accepts destination/result pairs from the pipeline over a valid/ready handshake and buffers them in a small FIFO.
- Drives the register file write port: global write enable, one-hot per-register select and write data.
- Drains one write per cycle unless the register file signals a stall; offers a read-bypass lookup of pending writes.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers; one-hot select width; must equal 2**ADDR_W.
- DEPTH, 2, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream write request valid.
- in_ready  out  1  queue can accept a request.
- in_addr  in  ADDR_W  destination register.
- in_data  in  DATA_W  result value.
- flush  in  1  synchronous discard of all pending writes.
- wr_stall  in  1  register file cannot take a write this cycle.
- regWrite  out  1  global write enable to the register file.
- decOut  out  NUM_REGS  one-hot register select; bit i drives register i's select input.
- writeData  out  DATA_W  data to the register file.
- q_addr  in  ADDR_W  bypass lookup address.
- q_hit  out  1  a pending write to q_addr exists.
- q_data  out  DATA_W  data of the youngest pending write to q_addr.
- count  out  $clog2(DEPTH)+1  number of pending entries.

Behaviour:
- Reset (reset=0, asynchronous): count=0, FIFO pointers=0, all entries invalid.
  - Outputs while in reset: regWrite=0, decOut=0, writeData=0, q_hit=0, q_data=0, in_ready=0.
- Reset applied mid-operation drops all pending writes immediately; no partial write is issued.
- in_ready=1 when reset=1, count<DEPTH and flush=0. No pass-through when full.
- Push: in_valid & in_ready at the edge enqueues {in_addr, in_data}.
  - in_addr==0: the request is accepted and discarded; nothing is enqueued; count is unchanged (r0 is hardwired).
- Head presentation: combinational from the registered head entry.
  - regWrite = (count!=0) & ~wr_stall & ~flush.
  - decOut = one-hot(head.addr) when regWrite=1, else 0.
  - writeData = head.data when count!=0, else 0.
- Pop: occurs at the edge where regWrite=1. The register file captures writeData on that same edge.
- Latency: a request accepted at edge N is presented in the cycle after edge N. With the queue empty it is written at edge N+1.
- Simultaneous push and pop: count unchanged; pointers both advance.
- Full (count==DEPTH) with pop: in_ready stays 0 that cycle. The push slot opens in the next cycle.
- wr_stall=1: head is held stable (addr/data unchanged) and regWrite=0. Pushes continue until full.
- flush=1 at an edge: count=0, pointers reset. Same cycle: regWrite=0 and in_ready=0. Flush has priority over push and pop.
- State machine (derived from count): EMPTY, PARTIAL, FULL.
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push without pop.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop without push.
  - Any state→EMPTY on flush or reset.
- Pointer wrap: modulo DEPTH. Full/empty are distinguished by count, not by pointer equality.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: q_hit=1 if any valid entry has addr==q_addr and q_addr!=0. q_data is the youngest such entry's data, combinational. The head being written this cycle still counts as pending.
- Not defined: q_hit=0, q_data=0. Ports remain present; no comparators are synthesized.

Decomposition:
- Package wb_pkg:
  - DATA_W, ADDR_W, NUM_REGS constants.
  - typedef wb_entry_t {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;}.
  - typedef wb_state_t enum {EMPTY, PARTIAL, FULL}.
- Sub-module wb_decoder_onehot: enable plus ADDR_W-bit address to NUM_REGS one-hot; all zeros when disabled.

Test Plan:
- Reset: assert reset=0 mid-traffic with count=2 → immediately regWrite=0, decOut=0, count=0; after release in_ready=1.
- Single write: push addr=5, data=0xDEADBEEF into empty queue → next cycle regWrite=1, decOut=32'h0000_0020, writeData=0xDEADBEEF; count returns to 0 after that edge.
- r0 discard: push addr=0, data=0x1234 → in_ready=1 for the handshake; count stays 0; regWrite never asserts.
- Stall and full:
  - wr_stall=1, push (3,0xA) then (7,0xB) → count=2, in_ready=0, regWrite=0.
  - Release stall → writes issue in order: decOut=0x8 then 0x80 on consecutive cycles.
- Simultaneous push/pop and flush:
  - count=1 with push (9,0xC) while head pops → count stays 1.
  - Then flush=1 → count=0 and regWrite=0 in the flush cycle.
- Bypass (WB_BYPASS_EN):
  - Pending (4,0x11) then (4,0x22), q_addr=4 → q_hit=1, q_data=0x22.
  - q_addr=0 → q_hit=0.
  - Without the macro: q_hit=0 always.
